// File: rtl/aludec_pkg.sv
// Shared types for the multicycle-aware ALU decoder: op classes, control codes,
// funct encodings and FSM states.
package aludec_pkg;

  typedef enum logic [1:0] {
    MEM_ADD = 2'b00,
    BR_SUB  = 2'b01,
    RTYPE   = 2'b10,
    IMM_OR  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    AND = 4'b0000,
    OR  = 4'b0001,
    ADD = 4'b0010,
    SUB = 4'b0011,
    MUL = 4'b0100,
    DIV = 4'b0101,
    SLL = 4'b0110,
    SRL = 4'b0111,
    NOT = 4'b1000,
    NOP = 4'b1111
  } alu_ctrl_e;

  localparam logic [5:0] F_AND = 6'b100000;
  localparam logic [5:0] F_OR  = 6'b100010;
  localparam logic [5:0] F_ADD = 6'b100100;
  localparam logic [5:0] F_SUB = 6'b100101;
  localparam logic [5:0] F_MUL = 6'b101010;
  localparam logic [5:0] F_DIV = 6'b011000;
  localparam logic [5:0] F_SLL = 6'b010010;
  localparam logic [5:0] F_SRL = 6'b010000;
  localparam logic [5:0] F_NOT = 6'b100111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  function automatic logic is_multicycle(alu_ctrl_e c);
    return (c == MUL) || (c == DIV);
  endfunction

endpackage

// File: rtl/aludec_comb.sv
// Pure combinational decode of aluop/funct into an ALU control code, an
// illegal-funct flag and a multicycle flag.
module aludec_comb
  import aludec_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6
) (
  input  logic [1:0]         i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  output alu_ctrl_e          o_ctrl,
  output logic               o_illegal,
  output logic               o_multicycle
);

  logic [5:0] w_funct6;
  assign w_funct6 = 6'(i_funct);

  always_comb begin
    o_ctrl    = NOP;
    o_illegal = 1'b0;
    unique case (aluop_e'(i_aluop))
      MEM_ADD: o_ctrl = ADD;
      BR_SUB:  o_ctrl = SUB;
      IMM_OR:  o_ctrl = OR;
      RTYPE: begin
        case (w_funct6)
          F_AND:   o_ctrl = AND;
          F_OR:    o_ctrl = OR;
          F_ADD:   o_ctrl = ADD;
          F_SUB:   o_ctrl = SUB;
          F_MUL:   o_ctrl = MUL;
          F_DIV:   o_ctrl = DIV;
          F_SLL:   o_ctrl = SLL;
          F_SRL:   o_ctrl = SRL;
          F_NOT:   o_ctrl = NOT;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_ctrl = NOP;
    endcase
  end

  assign o_multicycle = is_multicycle(o_ctrl);

endmodule

// File: rtl/aludec_mc.sv
// Registered ALU decoder that sequences multicycle mul/div ops with a start pulse,
// stall and completion strobe. Optional stall counter under ALUDEC_PERF_CNT_EN.
module aludec_mc
  import aludec_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [1:0]         aluop,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [CTRL_W-1:0]  alucontrol,
  output logic               alu_start_o,
  output logic               stall_o,
  output logic               valid_o,
  output logic               illegal_o
`ifdef ALUDEC_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  if (MUL_LAT < 2) begin : g_mul_lat_chk
    $error("MUL_LAT must be >= 2");
  end
  if (DIV_LAT < 2) begin : g_div_lat_chk
    $error("DIV_LAT must be >= 2");
  end

  alu_ctrl_e         w_ctrl;
  logic              w_illegal;
  logic              w_multi;
  logic              w_accept;
  logic              w_done;

  state_e            r_state;
  logic [CTRL_W-1:0] r_alucontrol;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start;
  logic              r_stall;
  logic              r_valid;
  logic              r_illegal;

  aludec_comb #(
    .FUNCT_W(FUNCT_W)
  ) u_comb (
    .i_aluop     (aluop),
    .i_funct     (funct),
    .o_ctrl      (w_ctrl),
    .o_illegal   (w_illegal),
    .o_multicycle(w_multi)
  );

  assign w_accept = valid_i & ready_o & ~flush_i;
  // A flush landing on the final EXEC cycle must still kill the completion strobe.
  assign w_done   = (r_state == EXEC) & (r_cnt == '0) & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_alucontrol <= CTRL_W'(NOP);
      r_cnt        <= '0;
      r_start      <= 1'b0;
      r_stall      <= 1'b0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alucontrol <= CTRL_W'(w_ctrl);
            if (w_multi) begin
              r_state <= EXEC;
              r_start <= 1'b1;
              r_stall <= 1'b1;
              r_cnt   <= (w_ctrl == DIV) ? DIV_CNT : MUL_CNT;
            end else begin
              r_valid   <= 1'b1;
              r_illegal <= w_illegal;
            end
          end
        end
        EXEC: begin
          if (flush_i) begin
            r_state      <= IDLE;
            r_stall      <= 1'b0;
            r_cnt        <= '0;
            r_alucontrol <= CTRL_W'(NOP);
          end else if (r_cnt == '0) begin
            r_state <= IDLE;
            r_stall <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALUDEC_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  assign ready_o     = (r_state == IDLE);
  assign alucontrol  = r_alucontrol;
  assign alu_start_o = r_start;
  assign stall_o     = r_stall;
  assign valid_o     = r_valid | w_done;
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_aludec_mc.sv
// Scoreboard bench for aludec_mc: a cycle-level reference model predicts results,
// busy windows and alucontrol; a negedge monitor compares against the DUT.
module tb_aludec_mc;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [5:0] funct = '0;
  logic [1:0] aluop = '0;
  logic       ready_o, alu_start_o, stall_o, valid_o, illegal_o;
  logic [3:0] alucontrol;
`ifdef ALUDEC_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  aludec_mc #(
    .CTRL_W (4),
    .FUNCT_W(6),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .funct      (funct),
    .aluop      (aluop),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .alucontrol (alucontrol),
    .alu_start_o(alu_start_o),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .illegal_o  (illegal_o)
`ifdef ALUDEC_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b0;
  int         m_first = -10;
  int         m_last = -10;
  logic [3:0] m_ctrl_now = 4'hf;
  logic [3:0] m_ctrl_pend = 4'hf;
  int         m_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode table straight from the op-class / funct listing.
  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] c, output logic ill);
    ill = 1'b0;
    case (op)
      2'b00: c = 4'h2;
      2'b01: c = 4'h3;
      2'b11: c = 4'h1;
      default: begin
        case (fn)
          6'b100000: c = 4'h0;
          6'b100010: c = 4'h1;
          6'b100100: c = 4'h2;
          6'b100101: c = 4'h3;
          6'b101010: c = 4'h4;
          6'b011000: c = 4'h5;
          6'b010010: c = 4'h6;
          6'b010000: c = 4'h7;
          6'b100111: c = 4'h8;
          default: begin
            c   = 4'hf;
            ill = 1'b1;
          end
        endcase
      end
    endcase
  endfunction

  function automatic bit busy_at(input int c);
    return (m_first <= c) && (c <= m_last);
  endfunction

  // Drive one cycle of inputs and let the model predict their effect.
  task automatic step(input bit v, input logic [1:0] op, input logic [5:0] fn, input bit fl);
    int         c;
    int         lat;
    bit         busy;
    logic [3:0] ctl;
    logic       ill;
    exp_t       e;
    @(posedge clk);
    #1;
    c          = cyc;
    m_ctrl_now = m_ctrl_pend;
    busy       = busy_at(c);
    if (busy && fl) begin
      m_last      = c;
      m_ctrl_pend = 4'hf;
      if (sb.size() > 0) e = sb.pop_back();
    end
    if (v && !busy && !fl) begin
      ref_decode(op, fn, ctl, ill);
      lat         = (ctl == 4'h4) ? MUL_LAT : (ctl == 4'h5) ? DIV_LAT : 1;
      m_ctrl_pend = ctl;
      if (lat > 1) begin
        m_first = c + 1;
        m_last  = c + lat;
        ill     = 1'b0;
      end
      e.due  = c + lat;
      e.ctrl = ctl;
      e.ill  = ill;
      sb.push_back(e);
    end
    valid_i = v;
    aluop   = op;
    funct   = fn;
    flush_i = fl;
  endtask

  always @(negedge clk) begin
    int   c;
    bit   busy;
    exp_t e;
    if (mon_en) begin
      c    = cyc;
      busy = busy_at(c);
      if (busy) m_stall++;
      chk("ready_o", 32'(ready_o), 32'(!busy));
      chk("stall_o", 32'(stall_o), 32'(busy));
      chk("alu_start_o", 32'(alu_start_o), 32'(c == m_first));
      chk("alucontrol", 32'(alucontrol), 32'(m_ctrl_now));
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("valid_o_unexpected", 32'(valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_cycle", 32'(c), 32'(e.due));
          chk("result_ctrl", 32'(alucontrol), 32'(e.ctrl));
          chk("result_illegal", 32'(illegal_o), 32'(e.ill));
        end
      end else if (sb.size() > 0 && sb[0].due <= c) begin
        chk("valid_o_missing", 32'(valid_o), 32'd1);
        e = sb.pop_front();
      end
    end
  end

  logic [5:0] legal_f[9];

  initial begin
    logic [1:0] op;
    logic [5:0] fn;
    int         n;
    legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b011000, 6'b010010, 6'b010000, 6'b100111};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_alucontrol", 32'(alucontrol), 32'hf);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_start", 32'(alu_start_o), 32'd0);
    chk("reset_illegal", 32'(illegal_o), 32'd0);
    mon_en = 1'b1;

    // Mul with a request held through the stall, then a second mul.
    step(1'b1, 2'b10, 6'b101010, 1'b0);
    repeat (5) step(1'b1, 2'b00, 6'b000000, 1'b0);
    step(1'b1, 2'b10, 6'b101010, 1'b0);
    repeat (6) step(1'b0, 2'b00, 6'b000000, 1'b0);
`ifdef ALUDEC_PERF_CNT_EN
    chk("stall_cnt_two_mul", stall_cnt_o, 32'd8);
`endif

    step(1'b1, 2'b10, 6'b100100, 1'b0);
    step(1'b1, 2'b00, 6'b000000, 1'b0);
    step(1'b1, 2'b01, 6'b000000, 1'b0);
    step(1'b1, 2'b11, 6'b000000, 1'b0);
    step(1'b1, 2'b10, 6'b111111, 1'b0);
    step(1'b1, 2'b10, 6'b100100, 1'b1);

    // Div aborted on its tenth EXEC cycle.
    step(1'b1, 2'b10, 6'b011000, 1'b0);
    repeat (9) step(1'b0, 2'b00, 6'b000000, 1'b0);
    step(1'b0, 2'b00, 6'b000000, 1'b1);
    repeat (2) step(1'b0, 2'b00, 6'b000000, 1'b0);

    // Mul flushed exactly on its completion cycle.
    step(1'b1, 2'b10, 6'b101010, 1'b0);
    repeat (3) step(1'b0, 2'b00, 6'b000000, 1'b0);
    step(1'b0, 2'b00, 6'b000000, 1'b1);
    repeat (2) step(1'b0, 2'b00, 6'b000000, 1'b0);

    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 8)];
      step($urandom_range(0, 3) != 0, op, fn, $urandom_range(0, 15) == 0);
    end

    n = 0;
    while ((sb.size() != 0 || busy_at(cyc)) && n < 40) begin
      step(1'b0, 2'b00, 6'b000000, 1'b0);
      n++;
    end
    if (n >= 40) chk("drain_timeout", 32'(sb.size()), 32'd0);
    step(1'b0, 2'b00, 6'b000000, 1'b0);
`ifdef ALUDEC_PERF_CNT_EN
    chk("stall_cnt_total", stall_cnt_o, 32'(m_stall));
`endif

    // Asynchronous reset in the middle of a mul.
    step(1'b1, 2'b10, 6'b101010, 1'b0);
    step(1'b0, 2'b00, 6'b000000, 1'b0);
    step(1'b0, 2'b00, 6'b000000, 1'b0);
    mon_en = 1'b0;
    chk("pre_reset_stall", 32'(stall_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_alucontrol", 32'(alucontrol), 32'hf);
    chk("midop_reset_stall", 32'(stall_o), 32'd0);
    chk("midop_reset_valid", 32'(valid_o), 32'd0);
    chk("midop_reset_start", 32'(alu_start_o), 32'd0);
    chk("midop_reset_ready", 32'(ready_o), 32'd1);
    chk("midop_reset_illegal", 32'(illegal_o), 32'd0);
`ifdef ALUDEC_PERF_CNT_EN
    chk("midop_reset_stall_cnt", stall_cnt_o, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset_valid", 32'(valid_o), 32'd0);
    chk("held_reset_stall", 32'(stall_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
